// File: rtl/n64_pkg.sv
// Shared constants and state encoding for the N64 controller poll scheduler.
// Optional macro N64_PROBE_EN adds the identify-probe state.
package n64_pkg;

   localparam logic [7:0] CMD_POLL = 8'h01;
   localparam logic [7:0] CMD_INFO = 8'h00;

   localparam int POLL_PERIOD_DEF = 1666667;
   localparam int RX_TIMEOUT_DEF  = 20000;
   localparam int MAX_RETRY_DEF   = 3;
   localparam int CNT_W_DEF       = 21;
   localparam int TX_START_WIN    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_TX_START,
      ST_WAIT_TX_END,
      ST_WAIT_RX,
      ST_WAIT_PERIOD
`ifdef N64_PROBE_EN
      , ST_PROBE
`endif
   } n64_state_e;

endpackage

// File: rtl/n64_interval_timer.sv
// Saturating up-counter with clear, load and a >= terminal-count compare.
module n64_interval_timer #(
   parameter int CNT_W = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] tc_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   // Saturation keeps a long wait from wrapping back below the compare value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

   assign tc = (cnt >= tc_val);

endmodule

// File: rtl/n64_poll_scheduler.sv
// Periodic poll sequencer for the N64 controller link write/read bit engines.
// Optional macro N64_PROBE_EN adds an identify probe and the dev_id port.
//
//   state            | meaning
//   ST_IDLE          | scheduling off, outputs quiet
//   ST_LAUNCH        | wait for write engine idle, then pulse wr_en (poll)
//   ST_PROBE         | as LAUNCH but sends identify (N64_PROBE_EN only)
//   ST_WAIT_TX_START | wait up to 4 cycles for wr_busy to rise
//   ST_WAIT_TX_END   | command shifting, wait for wr_busy to fall
//   ST_WAIT_RX       | response window, rd_done or timeout
//   ST_WAIT_PERIOD   | idle until the poll period elapses or poll_now
module n64_poll_scheduler
   import n64_pkg::*;
#(
   parameter int POLL_PERIOD = POLL_PERIOD_DEF,
   parameter int RX_TIMEOUT  = RX_TIMEOUT_DEF,
   parameter int MAX_RETRY   = MAX_RETRY_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        poll_now,
   output logic        wr_en,
   output logic [7:0]  wr_cmd,
   input  logic        wr_busy,
   input  logic        rd_done,
   input  logic [31:0] rd_data,
   output logic [31:0] buttons,
   output logic        buttons_valid,
   output logic        link_ok,
   output logic [7:0]  fail_cnt
`ifdef N64_PROBE_EN
   ,
   output logic [15:0] dev_id
`endif
);

   localparam logic [CNT_W-1:0] PER_TC    = CNT_W'(POLL_PERIOD - 1);
   localparam logic [CNT_W-1:0] RX_TC     = CNT_W'(RX_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TXS_TC    = CNT_W'(TX_START_WIN - 1);
   localparam logic [CNT_W-1:0] PER_START = CNT_W'(1);
   localparam logic [7:0]       RETRY_LAST = 8'(MAX_RETRY - 1);

   n64_state_e       state, state_nxt, launch_st, done_st;
   logic             launch, rsp_ok, rsp_fail, rsp_clr, per_clr;
   logic [7:0]       launch_cmd;
   logic             per_tc, rsp_tc;
   logic [CNT_W-1:0] rsp_tc_val;
   logic [7:0]       retry_cnt;

   // Period timer reads 1 in the wr_en cycle, so PER_TC lands launches exactly POLL_PERIOD apart.
   n64_interval_timer #(.CNT_W(CNT_W)) u_per_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (1'b1),
      .clr      (per_clr),
      .load     (launch),
      .load_val (PER_START),
      .tc_val   (PER_TC),
      .tc       (per_tc)
   );

   n64_interval_timer #(.CNT_W(CNT_W)) u_rsp_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (1'b1),
      .clr      (launch | rsp_clr),
      .load     (1'b0),
      .load_val ('0),
      .tc_val   (rsp_tc_val),
      .tc       (rsp_tc)
   );

   assign rsp_tc_val = (state == ST_WAIT_TX_START) ? TXS_TC : RX_TC;
   assign done_st    = enable ? ST_WAIT_PERIOD : ST_IDLE;

`ifdef N64_PROBE_EN
   logic need_probe;
   assign launch_st = need_probe ? ST_PROBE : ST_LAUNCH;
`else
   assign launch_st = ST_LAUNCH;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      launch     = 1'b0;
      launch_cmd = CMD_POLL;
      rsp_ok     = 1'b0;
      rsp_fail   = 1'b0;
      rsp_clr    = 1'b0;
      per_clr    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
`ifdef N64_PROBE_EN
               state_nxt = ST_PROBE;
`else
               state_nxt = ST_LAUNCH;
`endif
            end
         end
         ST_LAUNCH: begin
            if (!enable)
               state_nxt = ST_IDLE;
            else if (!wr_busy) begin
               launch    = 1'b1;
               state_nxt = ST_WAIT_TX_START;
            end
         end
`ifdef N64_PROBE_EN
         ST_PROBE: begin
            launch_cmd = CMD_INFO;
            if (!enable)
               state_nxt = ST_IDLE;
            else if (!wr_busy) begin
               launch    = 1'b1;
               state_nxt = ST_WAIT_TX_START;
            end
         end
`endif
         ST_WAIT_TX_START: begin
            if (wr_busy)
               state_nxt = ST_WAIT_TX_END;
            else if (rsp_tc) begin
               rsp_fail  = 1'b1;
               state_nxt = done_st;
            end
         end
         ST_WAIT_TX_END: begin
            if (!wr_busy) begin
               rsp_clr   = 1'b1;
               state_nxt = ST_WAIT_RX;
            end
         end
         ST_WAIT_RX: begin
            if (rd_done) begin
               rsp_ok    = 1'b1;
               state_nxt = done_st;
            end else if (rsp_tc) begin
               rsp_fail  = 1'b1;
               state_nxt = done_st;
            end
         end
         ST_WAIT_PERIOD: begin
            if (!enable)
               state_nxt = ST_IDLE;
            else if (poll_now) begin
               per_clr   = 1'b1;
               state_nxt = launch_st;
            end else if (per_tc)
               state_nxt = launch_st;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en         <= 1'b0;
         wr_cmd        <= CMD_POLL;
         buttons       <= '0;
         buttons_valid <= 1'b0;
         link_ok       <= 1'b0;
         fail_cnt      <= '0;
         retry_cnt     <= '0;
      end else begin
         wr_en         <= launch;
         buttons_valid <= 1'b0;
         if (launch)
            wr_cmd <= launch_cmd;
         if (rsp_ok) begin
            link_ok   <= 1'b1;
            retry_cnt <= '0;
            if (wr_cmd == CMD_POLL) begin
               buttons       <= rd_data;
               buttons_valid <= 1'b1;
            end
         end else if (rsp_fail) begin
            if (fail_cnt != 8'hFF)
               fail_cnt <= fail_cnt + 8'd1;
            if (retry_cnt >= RETRY_LAST) begin
               link_ok   <= 1'b0;
               retry_cnt <= '0;
            end else
               retry_cnt <= retry_cnt + 8'd1;
         end
      end
   end

`ifdef N64_PROBE_EN
   // A probe is owed after each probe launch until it succeeds, and after link loss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dev_id     <= '0;
         need_probe <= 1'b0;
      end else begin
         if (rsp_ok) begin
            need_probe <= 1'b0;
            if (wr_cmd == CMD_INFO)
               dev_id <= rd_data[31:16];
         end else if (rsp_fail && link_ok && (retry_cnt >= RETRY_LAST))
            need_probe <= 1'b1;
         else if (launch && (launch_cmd == CMD_INFO))
            need_probe <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Self-checking bench for n64_poll_scheduler: engine/reader model plus button scoreboard.
module tb_n64_poll_scheduler;
   import n64_pkg::*;

   localparam int PER      = 1000;
   localparam int RX_TO    = 200;
   localparam int BUSY_LEN = 10;
`ifdef N64_PROBE_EN
   localparam logic [7:0] FIRST_CMD = CMD_INFO;
`else
   localparam logic [7:0] FIRST_CMD = CMD_POLL;
`endif

   logic        clk = 1'b0;
   logic        rst_n, enable, poll_now;
   logic        wr_en, wr_busy, rd_done;
   logic [7:0]  wr_cmd, fail_cnt;
   logic [31:0] rd_data, buttons;
   logic        buttons_valid, link_ok;
`ifdef N64_PROBE_EN
   logic [15:0] dev_id;
`endif

   n64_poll_scheduler #(
      .POLL_PERIOD (PER),
      .RX_TIMEOUT  (RX_TO),
      .MAX_RETRY   (3),
      .CNT_W       (21)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .poll_now      (poll_now),
      .wr_en         (wr_en),
      .wr_cmd        (wr_cmd),
      .wr_busy       (wr_busy),
      .rd_done       (rd_done),
      .rd_data       (rd_data),
      .buttons       (buttons),
      .buttons_valid (buttons_valid),
      .link_ok       (link_ok),
      .fail_cnt      (fail_cnt)
`ifdef N64_PROBE_EN
      , .dev_id      (dev_id)
`endif
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   int          last_wr = 0;
   int          prev_wr = -1;
   bit          check_period = 1'b0;
   int          resp_delay = 150;
   logic [31:0] resp_data = '0;
   logic [7:0]  exp_cmd = CMD_POLL;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_wr(input int budget);
      int target;
      int n;
      target = wr_cnt + 1;
      n = 0;
      while (wr_cnt < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (wr_cnt < target) chk("wr_wait_timeout", 32'(wr_cnt), 32'(target));
   endtask

   task automatic poll_step(input int delay, input logic [31:0] data, input logic [7:0] cmd);
      resp_delay = delay;
      resp_data  = data;
      exp_cmd    = cmd;
      wait_wr(PER + 100);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Write engine + reader model; pushes the expected button word for good polls.
   initial begin
      int          cur_delay;
      logic [31:0] cur_data;
      logic [7:0]  cur_cmd;
      wr_busy = 1'b0;
      rd_done = 1'b0;
      rd_data = '0;
      forever begin
         @(posedge clk); #1;
         if (wr_en && rst_n) begin
            cur_delay = resp_delay;
            cur_data  = resp_data;
            cur_cmd   = exp_cmd;
            chk("wr_cmd", 32'(wr_cmd), 32'(cur_cmd));
            wr_busy = 1'b1;
            repeat (BUSY_LEN) @(posedge clk);
            #1 wr_busy = 1'b0;
            if (cur_delay >= 0) begin
               repeat (cur_delay) @(posedge clk);
               #1;
               rd_done = 1'b1;
               rd_data = cur_data;
               if (cur_delay <= RX_TO && cur_cmd == CMD_POLL) exp_q.push_back(cur_data);
               @(posedge clk); #1;
               rd_done = 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && buttons_valid) begin
         if (exp_q.size() == 0) chk("bv_unexpected", 32'd1, 32'd0);
         else chk("buttons_sb", buttons, exp_q.pop_front());
      end
      if (rst_n && wr_en) begin
         if (check_period && prev_wr >= 0) chk("period", 32'(cyc - prev_wr), 32'(PER));
         prev_wr = cyc;
         last_wr = cyc;
         wr_cnt++;
      end
   end

   initial begin
      int c;
      int rel;
      int wr_before;
      rst_n    = 1'b0;
      enable   = 1'b0;
      poll_now = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_cmd", 32'(wr_cmd), 32'h01);
      chk("rst_buttons", buttons, 32'd0);
      chk("rst_link", 32'(link_ok), 32'd0);
      chk("rst_fail", 32'(fail_cnt), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // steady polling with answers after 150 cycles
      resp_delay = 150; resp_data = 32'hA5A5_0F0F; exp_cmd = FIRST_CMD;
      enable = 1'b1;
      wait_wr(50);
      check_period = 1'b1;
      poll_step(150, 32'hA5A5_0F0F, CMD_POLL);
      poll_step(150, 32'h1234_5678, CMD_POLL);
      chk("link_up", 32'(link_ok), 32'd1);
      chk("fail_none", 32'(fail_cnt), 32'd0);
      chk("btn_poll2", buttons, 32'hA5A5_0F0F);

      // silent device: three timeouts drop link_ok
      poll_step(-1, 32'd0, CMD_POLL);
      chk("btn_poll3", buttons, 32'h1234_5678);
      poll_step(-1, 32'd0, CMD_POLL);
      chk("fail_1", 32'(fail_cnt), 32'd1);
      chk("link_1", 32'(link_ok), 32'd1);
      poll_step(-1, 32'd0, CMD_POLL);
      chk("fail_2", 32'(fail_cnt), 32'd2);
      chk("link_2", 32'(link_ok), 32'd1);
      poll_step(200, 32'hDEAD_BEEF, FIRST_CMD);
      chk("fail_3", 32'(fail_cnt), 32'd3);
      chk("link_3", 32'(link_ok), 32'd0);
      chk("btn_kept", buttons, 32'h1234_5678);

      // answer on the last timeout cycle wins; one cycle later is a failure
      poll_step(201, 32'hCAFE_F00D, CMD_POLL);
      chk("edge_fail", 32'(fail_cnt), 32'd3);
      chk("edge_link", 32'(link_ok), 32'd1);
`ifdef N64_PROBE_EN
      chk("probe_dev", 32'(dev_id), 32'h0000_DEAD);
`else
      chk("edge_btn", buttons, 32'hDEAD_BEEF);
`endif
      poll_step(150, 32'h0F0F_A5A5, CMD_POLL);
      chk("late_fail", 32'(fail_cnt), 32'd4);
      chk("late_link", 32'(link_ok), 32'd1);

      // poll_now mid-period
      check_period = 1'b0;
      resp_data = 32'h5555_AAAA;
      repeat (500) @(negedge clk);
      #1;
      c = cyc;
      poll_now = 1'b1;
      @(negedge clk); #1;
      poll_now = 1'b0;
      wait_wr(20);
      chk("poll_now_lat", 32'(last_wr - c), 32'd2);
      check_period = 1'b1;
      poll_step(150, 32'h1111_2222, CMD_POLL);
      chk("btn_pollnow", buttons, 32'h5555_AAAA);

      // enable drop while the command is shifting
      repeat (3) @(negedge clk);
      #1;
      enable = 1'b0;
      check_period = 1'b0;
      wr_before = wr_cnt;
      repeat (2500) @(negedge clk);
      #1;
      chk("dis_no_wr", 32'(wr_cnt), 32'(wr_before));
      chk("dis_btn", buttons, 32'h1111_2222);
      chk("dis_link", 32'(link_ok), 32'd1);

      // re-enable, then reset while waiting for a response
`ifdef N64_PROBE_EN
      resp_data = 32'h0500_0000;
`else
      resp_data = 32'h3333_4444;
`endif
      resp_delay = 150; exp_cmd = FIRST_CMD;
      enable = 1'b1;
      wait_wr(50);
      poll_step(-1, 32'd0, CMD_POLL);
`ifdef N64_PROBE_EN
      chk("reen_dev", 32'(dev_id), 32'h0000_0500);
`else
      chk("reen_btn", buttons, 32'h3333_4444);
`endif
      repeat (20) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rrst_wr_en", 32'(wr_en), 32'd0);
      chk("rrst_wr_cmd", 32'(wr_cmd), 32'h01);
      chk("rrst_buttons", buttons, 32'd0);
      chk("rrst_bv", 32'(buttons_valid), 32'd0);
      chk("rrst_link", 32'(link_ok), 32'd0);
      chk("rrst_fail", 32'(fail_cnt), 32'd0);
`ifdef N64_PROBE_EN
      chk("rrst_dev", 32'(dev_id), 32'd0);
`endif
      resp_delay = 150; resp_data = 32'h7777_8888; exp_cmd = FIRST_CMD;
      @(negedge clk); #1;
      rel = cyc;
      rst_n = 1'b1;
      wait_wr(50);
      chk("rst_relaunch", 32'(last_wr - rel), 32'd2);
      repeat (300) @(negedge clk);
      #1;
      chk("post_link", 32'(link_ok), 32'd1);
`ifdef N64_PROBE_EN
      chk("post_dev", 32'(dev_id), 32'h0000_7777);
      chk("post_btn", buttons, 32'd0);
`else
      chk("post_btn", buttons, 32'h7777_8888);
`endif
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
